// File: rtl/demux_pkg.sv
// Shared defaults for the 1-to-N stream demultiplexer and a ceil(log2) helper
// for deriving select widths from a channel count.
package demux_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEMUX_WIDTH = 32;
  localparam int unsigned DEMUX_N     = 4;
  localparam int unsigned DEMUX_SEL_W = clog2(DEMUX_N);

endpackage

// File: rtl/demux_slot.sv
// One-entry output register stage with valid/ready; load is only asserted by
// the parent when the slot is free, so a stalled word never changes.
module demux_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load wins over a same-cycle drain, so back-to-back words have no bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/demux_1_n_stream.sv
// Registered 1-to-N stream demux: select decode, in_ready mux and sel_err pulse.
// Optional broadcast input enabled by defining DEMUX_BCAST_EN.
module demux_1_n_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH,
  parameter int unsigned N     = DEMUX_N,
  parameter int unsigned SEL_W = DEMUX_SEL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic               in_bcast,
`endif
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               sel_err
);

  logic [N-1:0] free;
  logic [N-1:0] sel_hit;
  logic [N-1:0] load;
  logic         sel_oob;
  logic         bcast;
  logic         accept;
  logic         sel_err_q, sel_err_d;

  always_comb begin
`ifdef DEMUX_BCAST_EN
    bcast = in_bcast;
`else
    bcast = 1'b0;
`endif
    free    = ~out_valid | out_ready;
    sel_hit = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
    // No channel matched: the word is swallowed, so the input is always ready.
    sel_oob  = ~|sel_hit;
    in_ready = bcast ? &free : (sel_oob | |(sel_hit & free));
    accept   = in_valid & in_ready;
    load     = '0;
    if (accept) load = bcast ? '1 : sel_hit;
    sel_err_d = accept & sel_oob & ~bcast;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[k]),
      .d     (in_data),
      .ready (out_ready[k]),
      .valid (out_valid[k]),
      .q     (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Directed bench for demux_1_n_stream: a 4-channel instance plus a 3-channel
// instance exercising the out-of-range select path.
module tb_demux_1_n_stream;

  logic         clk;
  logic         reset;

  logic         a_in_valid, a_in_ready;
  logic [31:0]  a_in_data;
  logic [1:0]   a_in_sel;
  logic [3:0]   a_out_valid, a_out_ready;
  logic [127:0] a_out_data;
  logic         a_sel_err;
`ifdef DEMUX_BCAST_EN
  logic         a_in_bcast;
  logic         b_in_bcast;
`endif

  logic         b_in_valid, b_in_ready;
  logic [31:0]  b_in_data;
  logic [1:0]   b_in_sel;
  logic [2:0]   b_out_valid, b_out_ready;
  logic [95:0]  b_out_data;
  logic         b_sel_err;

  int unsigned  n_checks;
  int unsigned  n_pass;

  demux_1_n_stream #(.WIDTH(32), .N(4), .SEL_W(2)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_sel    (a_in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (a_in_bcast),
`endif
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .sel_err   (a_sel_err)
  );

  demux_1_n_stream #(.WIDTH(32), .N(3), .SEL_W(2)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_sel    (b_in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast  (b_in_bcast),
`endif
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .sel_err   (b_sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] a_slot(input int unsigned k);
    return a_out_data[k*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    reset       = 1'b0;
    a_in_valid  = 1'b0;
    a_in_data   = '0;
    a_in_sel    = '0;
    a_out_ready = '0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_in_sel    = '0;
    b_out_ready = '1;
`ifdef DEMUX_BCAST_EN
    a_in_bcast  = 1'b0;
    b_in_bcast  = 1'b0;
`endif
    #2 reset = 1'b1;
    #1;
    check("rst_valid", 64'(a_out_valid), 64'h0);
    check("rst_data",  64'(a_out_data[63:0]), 64'h0);
    check("rst_err",   64'(a_sel_err), 64'h0);
    tick();
    tick();
    #2 reset = 1'b0;
    tick();

    // single word to channel 2
    a_out_ready = 4'hF;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd2;
    a_in_data   = 32'hA5A5_0001;
    #1 check("t1_ready", 64'(a_in_ready), 64'h1);
    tick();
    a_in_valid = 1'b0;
    check("t1_valid", 64'(a_out_valid), 64'h4);
    check("t1_data2", 64'(a_slot(2)), 64'hA5A5_0001);
    tick();
    check("t1_drain", 64'(a_out_valid), 64'h0);
    check("t1_hold",  64'(a_slot(2)), 64'hA5A5_0001);

    // back-to-back to channel 1
    a_in_valid = 1'b1;
    a_in_sel   = 2'd1;
    a_in_data  = 32'h11;
    tick();
    check("t2_d11", 64'(a_slot(1)), 64'h11);
    check("t2_v11", 64'(a_out_valid), 64'h2);
    a_in_data = 32'h22;
    #1 check("t2_rdy", 64'(a_in_ready), 64'h1);
    tick();
    check("t2_d22", 64'(a_slot(1)), 64'h22);
    a_in_data = 32'h33;
    #1 check("t2_rdy2", 64'(a_in_ready), 64'h1);
    tick();
    check("t2_d33", 64'(a_slot(1)), 64'h33);
    a_in_valid = 1'b0;
    tick();
    check("t2_drain", 64'(a_out_valid), 64'h0);

    // channel 0 stalled
    a_out_ready = 4'b1110;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd0;
    a_in_data   = 32'hC0;
    #1 check("t3_rdy_free", 64'(a_in_ready), 64'h1);
    tick();
    check("t3_v0", 64'(a_out_valid), 64'h1);
    a_in_data = 32'hDD;
    #1 check("t3_rdy_full", 64'(a_in_ready), 64'h0);
    tick();
    check("t3_hold_v", 64'(a_out_valid), 64'h1);
    check("t3_hold_d", 64'(a_slot(0)), 64'hC0);
    a_in_sel  = 2'd3;
    a_in_data = 32'h33C;
    #1 check("t3_rdy3", 64'(a_in_ready), 64'h1);
    tick();
    a_in_valid = 1'b0;
    check("t3_v03", 64'(a_out_valid), 64'h9);
    check("t3_d3",  64'(a_slot(3)), 64'h33C);
    check("t3_d0",  64'(a_slot(0)), 64'hC0);
    tick();
    check("t3_drain3", 64'(a_out_valid), 64'h1);

    // fill to 4'b1011, then async reset
    a_out_ready = 4'b0000;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd1;
    a_in_data   = 32'h101;
    tick();
    a_in_sel    = 2'd3;
    a_in_data   = 32'h303;
    tick();
    a_in_valid  = 1'b0;
    check("t5_pre", 64'(a_out_valid), 64'hB);
    #2 reset = 1'b1;
    #1 check("t5_async", 64'(a_out_valid), 64'h0);
    #2 reset = 1'b0;
    tick();
    tick();
    check("t5_post", 64'(a_out_valid), 64'h0);
    check("t5_err",  64'(a_sel_err), 64'h0);

    // N=3 out-of-range select
    b_in_valid = 1'b1;
    b_in_sel   = 2'd3;
    b_in_data  = 32'hBAD;
    #1 check("t4_rdy", 64'(b_in_ready), 64'h1);
    tick();
    b_in_valid = 1'b0;
    check("t4_err1",  64'(b_sel_err), 64'h1);
    check("t4_valid", 64'(b_out_valid), 64'h0);
    tick();
    check("t4_err0", 64'(b_sel_err), 64'h0);
    b_in_valid = 1'b1;
    b_in_sel   = 2'd2;
    b_in_data  = 32'h222;
    tick();
    b_in_valid = 1'b0;
    check("t4_v2",   64'(b_out_valid), 64'h4);
    check("t4_d2",   64'(b_out_data[95:64]), 64'h222);
    check("t4_noerr", 64'(b_sel_err), 64'h0);

`ifdef DEMUX_BCAST_EN
    // broadcast blocked by stalled channel 2, then released
    a_out_ready = 4'b1011;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd2;
    a_in_data   = 32'h77;
    tick();
    a_in_bcast  = 1'b1;
    a_in_sel    = 2'd0;
    a_in_data   = 32'h5A;
    #1 check("t6_rdy0", 64'(a_in_ready), 64'h0);
    tick();
    check("t6_hold", 64'(a_out_valid), 64'h4);
    check("t6_d2",   64'(a_slot(2)), 64'h77);
    a_out_ready = 4'hF;
    #1 check("t6_rdy1", 64'(a_in_ready), 64'h1);
    tick();
    a_in_valid = 1'b0;
    a_in_bcast = 1'b0;
    a_out_ready = 4'h0;
    check("t6_valid", 64'(a_out_valid), 64'hF);
    for (int unsigned k = 0; k < 4; k++) check("t6_data", 64'(a_slot(k)), 64'h5A);
    check("t6_err", 64'(a_sel_err), 64'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
